// File: rtl/gpu_wb_pkg.sv
// Shared constants, state encodings and burst layout for the pixel writeback path.
package gpu_wb_pkg;
  localparam int VRAM_PAIRX_W = 9;
  localparam int VRAM_Y_W     = 9;
  localparam int WB_PAIRS     = 8;
  localparam int WB_S         = $clog2(WB_PAIRS);
  localparam int WB_ADDR_W    = VRAM_Y_W + VRAM_PAIRX_W - WB_S;

  typedef enum logic {F_EMPTY, F_FILLING} fill_st_e;
  typedef enum logic {P_EMPTY, P_VALID}   pend_st_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0]    addr;
    logic [32*WB_PAIRS-1:0]  data;
    logic [2*WB_PAIRS-1:0]   mask;
  } burst_t;

  // {y, x[8:s]} right-aligned; callers truncate to their address width
  function automatic logic [VRAM_Y_W+VRAM_PAIRX_W-1:0] blkAddr(
    input logic [VRAM_PAIRX_W-1:0] x,
    input logic [VRAM_Y_W-1:0]     y,
    input int unsigned             s = WB_S);
    return {y, x} >> s;
  endfunction
endpackage

// File: rtl/gpu_wb_linebuf.sv
// One burst-wide register with per-pixel merge, clear and all-ones detect.
module gpu_wb_linebuf #(
  parameter  int PAIRS = 8,
  localparam int S     = $clog2(PAIRS)
) (
  input  logic                        clk,
  input  logic                        i_nRst,
  input  logic                        i_clr,
  input  logic                        i_start,
  input  logic                        i_wrEn,
  input  logic [S-1:0]                i_slot,
  input  logic [1:0]                  i_pixEn,
  input  logic [31:0]                 i_write32,
  output logic [PAIRS-1:0][1:0][15:0] o_data,
  output logic [PAIRS-1:0][1:0]       o_mask,
  output logic [PAIRS-1:0][1:0][15:0] o_mrgData,
  output logic [PAIRS-1:0][1:0]       o_mrgMask,
  output logic                        o_mrgFull
);
  logic [PAIRS-1:0][1:0][15:0] data_q, data_d;
  logic [PAIRS-1:0][1:0]       mask_q, mask_d;

  // i_start merges onto a blank burst so a block-change pair can open the new block
  always_comb begin
    o_mrgData = i_start ? '0 : data_q;
    o_mrgMask = i_start ? '0 : mask_q;
    if (i_wrEn) begin
      for (int p = 0; p < 2; p++) begin
        if (i_pixEn[p]) begin
          o_mrgData[i_slot][p] = i_write32[16*p +: 16];
          o_mrgMask[i_slot][p] = 1'b1;
        end
      end
    end
    o_mrgFull = &o_mrgMask;
    data_d = data_q;
    mask_d = mask_q;
    if (i_clr) begin
      data_d = '0;
      mask_d = '0;
    end else if (i_wrEn) begin
      data_d = o_mrgData;
      mask_d = o_mrgMask;
    end
  end

  always_ff @(posedge clk or negedge i_nRst) begin
    if (!i_nRst) begin
      data_q <= '0;
      mask_q <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign o_data = data_q;
  assign o_mask = mask_q;
endmodule

// File: rtl/gpu_pixel_writeback.sv
// Coalesces pixel pairs into masked VRAM bursts using a fill buffer and one pending buffer.
module gpu_pixel_writeback
  import gpu_wb_pkg::*;
#(
  parameter  int PAIRS         = 8,
  parameter  bit CLOSE_ON_FULL = 1'b1,
  localparam int S             = $clog2(PAIRS),
  localparam int ADDR_W        = VRAM_Y_W + VRAM_PAIRX_W - S
) (
  input  logic                    clk,
  input  logic                    i_nRst,
  input  logic                    i_pixValid,
  output logic                    o_pixReady,
  input  logic [VRAM_PAIRX_W-1:0] i_pairX,
  input  logic [VRAM_Y_W-1:0]     i_pairY,
  input  logic [31:0]             i_write32,
  input  logic [1:0]              i_pixEn,
  input  logic                    i_flush,
  output logic                    o_wrValid,
  input  logic                    i_wrReady,
  output logic [ADDR_W-1:0]       o_wrAddr,
  output logic [32*PAIRS-1:0]     o_wrData,
  output logic [2*PAIRS-1:0]      o_wrMask,
  output logic                    o_idle
);
  fill_st_e fillSt_q, fillSt_d;
  pend_st_e pendSt_q, pendSt_d;
  logic     flushPend_q, flushPend_d;
  logic [ADDR_W-1:0]           fillAddr_q, fillAddr_d, pendAddr_q, pendAddr_d, inBlk;
  logic [PAIRS-1:0][1:0][15:0] fillData, mrgData, pendData_q, pendData_d;
  logic [PAIRS-1:0][1:0]       fillMask, mrgMask, pendMask_q, pendMask_d;
  logic mrgFull, pixAct, act, diffBlk, pendBusy, pendFree, wrHs;
  logic closeBlk, closeFull, closeFlush, fillStart;

  assign inBlk      = ADDR_W'(blkAddr(i_pairX, i_pairY, S));
  assign pixAct     = i_pixValid & (i_pixEn != 2'b00);
  assign diffBlk    = (fillSt_q == F_FILLING) & (inBlk != fillAddr_q);
  assign wrHs       = (pendSt_q == P_VALID) & i_wrReady;
  assign pendBusy   = (pendSt_q == P_VALID) & ~i_wrReady;
  assign pendFree   = ~pendBusy;
  assign o_pixReady = ~flushPend_q & ~(pixAct & diffBlk & pendBusy);
  assign act        = pixAct & o_pixReady;
  // block-change close ships the old contents; full/flush close ships the merged view
  assign closeBlk   = act & diffBlk;
  assign closeFlush = flushPend_q & (fillSt_q == F_FILLING) & pendFree;
  assign closeFull  = CLOSE_ON_FULL & mrgFull & pendFree & ~closeBlk;
  assign fillStart  = (fillSt_q == F_EMPTY) | diffBlk;

  gpu_wb_linebuf #(.PAIRS(PAIRS)) u_fill (
    .clk       (clk),
    .i_nRst    (i_nRst),
    .i_clr     (closeFull | closeFlush),
    .i_start   (fillStart),
    .i_wrEn    (act),
    .i_slot    (i_pairX[S-1:0]),
    .i_pixEn   (i_pixEn),
    .i_write32 (i_write32),
    .o_data    (fillData),
    .o_mask    (fillMask),
    .o_mrgData (mrgData),
    .o_mrgMask (mrgMask),
    .o_mrgFull (mrgFull)
  );

  always_comb begin
    fillSt_d    = fillSt_q;
    fillAddr_d  = fillAddr_q;
    pendSt_d    = pendSt_q;
    pendAddr_d  = pendAddr_q;
    pendData_d  = pendData_q;
    pendMask_d  = pendMask_q;
    flushPend_d = flushPend_q;
    if (wrHs) begin
      pendSt_d   = P_EMPTY;
      pendAddr_d = '0;
      pendData_d = '0;
      pendMask_d = '0;
    end
    if (closeBlk) begin
      pendSt_d   = P_VALID;
      pendAddr_d = fillAddr_q;
      pendData_d = fillData;
      pendMask_d = fillMask;
    end else if (closeFull | closeFlush) begin
      pendSt_d   = P_VALID;
      pendAddr_d = fillAddr_q;
      pendData_d = mrgData;
      pendMask_d = mrgMask;
    end
    if (closeFull | closeFlush) fillSt_d = F_EMPTY;
    else if (act) begin
      fillSt_d   = F_FILLING;
      fillAddr_d = inBlk;
    end
    if (i_flush) flushPend_d = 1'b1;
    else if (flushPend_q & ((fillSt_q == F_EMPTY) | closeFlush)) flushPend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge i_nRst) begin
    if (!i_nRst) begin
      fillSt_q    <= F_EMPTY;
      fillAddr_q  <= '0;
      pendSt_q    <= P_EMPTY;
      pendAddr_q  <= '0;
      pendData_q  <= '0;
      pendMask_q  <= '0;
      flushPend_q <= 1'b0;
    end else begin
      fillSt_q    <= fillSt_d;
      fillAddr_q  <= fillAddr_d;
      pendSt_q    <= pendSt_d;
      pendAddr_q  <= pendAddr_d;
      pendData_q  <= pendData_d;
      pendMask_q  <= pendMask_d;
      flushPend_q <= flushPend_d;
    end
  end

  assign o_wrValid = (pendSt_q == P_VALID);
  assign o_wrAddr  = pendAddr_q;
  assign o_wrData  = pendData_q;
  assign o_wrMask  = pendMask_q;
  assign o_idle    = (fillSt_q == F_EMPTY) & (pendSt_q == P_EMPTY) & ~flushPend_q;
endmodule

// File: tb/tb_gpu_pixel_writeback.sv
// Directed scoreboard bench for gpu_pixel_writeback with PAIRS = 8.
module tb_gpu_pixel_writeback;
  import gpu_wb_pkg::*;

  logic clk, rst_n;
  logic i_pixValid, o_pixReady, i_flush, o_wrValid, i_wrReady, o_idle;
  logic [8:0] i_pairX, i_pairY;
  logic [31:0] i_write32;
  logic [1:0] i_pixEn;
  logic [WB_ADDR_W-1:0] o_wrAddr;
  logic [32*WB_PAIRS-1:0] o_wrData;
  logic [2*WB_PAIRS-1:0] o_wrMask;

  int checks = 0, errors = 0, nBurst = 0;
  burst_t expq[$];

  gpu_pixel_writeback #(.PAIRS(WB_PAIRS), .CLOSE_ON_FULL(1'b1)) dut (
    .clk(clk), .i_nRst(rst_n), .i_pixValid(i_pixValid), .o_pixReady(o_pixReady),
    .i_pairX(i_pairX), .i_pairY(i_pairY), .i_write32(i_write32), .i_pixEn(i_pixEn),
    .i_flush(i_flush), .o_wrValid(o_wrValid), .i_wrReady(i_wrReady),
    .o_wrAddr(o_wrAddr), .o_wrData(o_wrData), .o_wrMask(o_wrMask), .o_idle(o_idle));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted burst must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && o_wrValid && i_wrReady) begin
      burst_t e;
      nBurst++;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL burst_unexpected act addr=%h mask=%h req=none", o_wrAddr, o_wrMask);
      end else begin
        e = expq.pop_front();
        if (o_wrAddr !== e.addr || o_wrData !== e.data || o_wrMask !== e.mask) begin
          errors++;
          $display("FAIL burst act addr=%h mask=%h data=%h req addr=%h mask=%h data=%h",
                   o_wrAddr, o_wrMask, o_wrData, e.addr, e.mask, e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic send(input int x, input int y, input logic [31:0] d, input logic [1:0] en);
    int t = 0;
    i_pixValid = 1; i_pairX = x[8:0]; i_pairY = y[8:0]; i_write32 = d; i_pixEn = en;
    @(negedge clk);
    while (!o_pixReady && t < 100) begin t++; @(negedge clk); end
    if (!o_pixReady) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    i_pixValid = 0; i_pixEn = 2'b00;
  endtask

  task automatic flush();
    i_flush = 1;
    @(posedge clk); #1;
    i_flush = 0;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    @(negedge clk);
    while (!(o_idle && !o_wrValid && expq.size() == 0) && t < 100) begin t++; @(negedge clk); end
    chk(nm, {63'd0, o_idle}, 64'd1);
    chk({nm, "_drained"}, expq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    burst_t b;
    int nb;
    rst_n = 0; i_pixValid = 0; i_pairX = 0; i_pairY = 0; i_write32 = 0;
    i_pixEn = 0; i_flush = 0; i_wrReady = 1;
    #23;
    chk("rst_wrValid", {63'd0, o_wrValid}, 0);
    chk("rst_pixReady", {63'd0, o_pixReady}, 1);
    chk("rst_idle", {63'd0, o_idle}, 1);
    chk("rst_wrAddr", {49'd0, o_wrAddr}, 0);
    chk("rst_wrMask", {48'd0, o_wrMask}, 0);
    chk("rst_wrData_nz", {63'd0, |o_wrData}, 0);
    @(posedge clk); #1; rst_n = 1;

    // Full block on Y=5 closes on the mask becoming all-ones
    b = '0; b.addr = 15'h140; b.mask = 16'hFFFF;
    for (int k = 0; k < 8; k++) b.data[32*k +: 32] = 32'h00010000 * k + k;
    expq.push_back(b);
    nb = nBurst;
    for (int k = 0; k < 8; k++) send(k, 5, 32'h00010000 * k + k, 2'b11);
    @(negedge clk);
    chk("full_latency_wrValid", {63'd0, o_wrValid}, 1);
    @(negedge clk);
    chk("full_one_cycle", {63'd0, o_wrValid}, 0);
    wait_idle("t1_idle");
    chk("t1_nburst", nBurst - nb, 1);

    // Two partial blocks: block change closes the first, flush the second
    b = '0; b.addr = 15'h1C0; b.mask = 16'h0040; b.data[32*3 +: 32] = 32'h00002222;
    expq.push_back(b);
    b = '0; b.addr = 15'h1C1; b.mask = 16'h0200; b.data[32*4 +: 32] = 32'h33330000;
    expq.push_back(b);
    send(3, 7, 32'h11112222, 2'b01);
    send(12, 7, 32'h33334444, 2'b10);
    flush();
    @(negedge clk);
    chk("flush_pixReady_low", {63'd0, o_pixReady}, 0);
    wait_idle("t2_idle");

    // Backpressure with three blocks
    i_wrReady = 0;
    for (int k = 0; k < 3; k++) begin
      b = '0; b.addr = 15'h040 + 15'(k); b.mask = 16'h0003;
      b.data[31:0] = 32'hD0D0_0000 + 32'(k);
      expq.push_back(b);
    end
    nb = nBurst;
    send(0, 1, 32'hD0D0_0000, 2'b11);
    send(8, 1, 32'hD0D0_0001, 2'b11);
    i_pixValid = 1; i_pairX = 9'd16; i_pairY = 9'd1; i_write32 = 32'hD0D0_0002; i_pixEn = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_pixReady_low", {63'd0, o_pixReady}, 0);
      chk("bp_wrValid", {63'd0, o_wrValid}, 1);
      chk("bp_addr_stable", {49'd0, o_wrAddr}, 64'h40);
      chk("bp_mask_stable", {48'd0, o_wrMask}, 64'h3);
      chk("bp_data_stable", {32'd0, o_wrData[31:0]}, 64'hD0D00000);
    end
    @(posedge clk); #1; i_wrReady = 1;
    @(negedge clk);
    chk("bp_release_ready", {63'd0, o_pixReady}, 1);
    @(posedge clk); #1; i_pixValid = 0; i_pixEn = 2'b00;
    flush();
    wait_idle("t3_idle");
    chk("t3_nburst", nBurst - nb, 3);

    // Same slot written twice: last write wins per pixel
    b = '0; b.addr = 15'h0C0; b.mask = 16'h0030; b.data[32*2 +: 32] = 32'hAAAAFFFF;
    expq.push_back(b);
    send(2, 3, 32'hAAAA5555, 2'b11);
    send(2, 3, 32'h1234FFFF, 2'b01);
    flush();
    wait_idle("t4_idle");

    // Disabled pairs never open a buffer
    nb = nBurst;
    send(0, 4, 32'hFFFFFFFF, 2'b00);
    send(9, 4, 32'hFFFFFFFF, 2'b00);
    chk("en00_idle", {63'd0, o_idle}, 1);
    flush();
    @(negedge clk);
    chk("en00_flushpend_idle", {63'd0, o_idle}, 0);
    @(negedge clk);
    chk("en00_idle_2cyc", {63'd0, o_idle}, 1);
    chk("en00_no_burst", nBurst - nb, 0);
    @(posedge clk); #1;

    // Reset while a burst is waiting on the arbiter
    i_wrReady = 0;
    send(0, 9, 32'hBEEFBEEF, 2'b11);
    flush();
    begin
      int t = 0;
      @(negedge clk);
      while (!o_wrValid && t < 20) begin t++; @(negedge clk); end
      chk("rst_pre_wrValid", {63'd0, o_wrValid}, 1);
    end
    @(posedge clk); #1; rst_n = 0;
    #1;
    chk("midrst_wrValid", {63'd0, o_wrValid}, 0);
    chk("midrst_idle", {63'd0, o_idle}, 1);
    chk("midrst_pixReady", {63'd0, o_pixReady}, 1);
    chk("midrst_mask", {48'd0, o_wrMask}, 0);
    @(posedge clk); #1; rst_n = 1; i_wrReady = 1;
    b = '0; b.addr = 15'h082; b.mask = 16'hFFFF;
    for (int k = 0; k < 8; k++) b.data[32*k +: 32] = 32'hC0000000 | 32'(k * 17);
    expq.push_back(b);
    for (int k = 0; k < 8; k++) send(16 + k, 2, 32'hC0000000 | 32'(k * 17), 2'b11);
    wait_idle("t6_idle");

    chk("final_queue_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
